camera_ctrl: RTL and testbench
==============================

CAMERA_CTRL -- requirements
Module: camera_ctrl

Interface
REQ-001 Parameter PIPE_LAT, default 24, SHALL set the cycles cnt is held stable before a camera load; the FP convert/mult/mult/add chain settles within this time.
REQ-002 Parameter CNT_MAX, default 32'h00FF_FFFF, SHALL set the saturation value of cnt.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_valid  input  1  one-cycle pulse: a key press is reported on key_code.
REQ-006 key_code  input  3  press code: 000 UPOS, 001 UNEG, 010 VPOS, 011 VNEG, 100 WPOS, 101 WNEG; 110 and 111 are invalid.
REQ-007 key_release  input  1  one-cycle pulse: the held key has been released.
REQ-008 frame_done  input  1  one-cycle pulse: the renderer has finished a frame, so the camera may change.
REQ-009 v0, v1, v2  output  1 each  one-hot phase rotation driven to the camera datapath.
REQ-010 ld_curr_camera  output  1  camera-register load request to the camera datapath.
REQ-011 key  output  3  latched key code driven to the camera datapath.
REQ-012 cnt  output  32  unsigned count of held cycles, used as the move magnitude.
REQ-013 render_start  output  1  one-cycle pulse: the renderer may start the next frame.
REQ-014 busy  output  1  high while state is COMPUTE, LOAD or DONE.

Function
REQ-015 Phase: v0,v1,v2 SHALL be one-hot at all times and rotate v0->v1->v2->v0 every cycle, free-running and independent of the FSM.
REQ-016 FSM states SHALL be IDLE, HOLD, COMPUTE, LOAD and DONE; all outputs SHALL be registered.
REQ-017 IDLE: key_valid with a valid code SHALL latch key_code into key, clear cnt to 0 and go to HOLD.
REQ-018 IDLE: key_valid with code 110 or 111 SHALL be ignored.
REQ-019 IDLE: frame_done SHALL pulse render_start the next cycle with no camera load.
REQ-020 IDLE: if key_valid and key_release arrive in the same cycle, the FSM SHALL stay in IDLE and key SHALL be unchanged.
REQ-021 HOLD: cnt SHALL increment by 1 each cycle, saturating at CNT_MAX.
REQ-022 HOLD: key_valid SHALL be ignored; the first key wins until release.
REQ-023 HOLD: key_release SHALL set the internal flag rel_pend; cnt stops counting.
REQ-024 HOLD: frame_done SHALL move the FSM to COMPUTE; cnt then freezes.
REQ-025 HOLD: if rel_pend is set and cnt=0, the FSM SHALL return to IDLE.
REQ-026 COMPUTE: cnt and key SHALL stay constant for exactly PIPE_LAT cycles.
REQ-027 COMPUTE exit: the FSM SHALL then enter LOAD on the first cycle in which v0=1, waiting 0-2 extra cycles for alignment.
REQ-028 LOAD: lasts exactly 3 cycles, aligned to v0, v1, v2; ld_curr_camera=1 in all three and 0 in every other state.
REQ-029 DONE: lasts 1 cycle with render_start=1.
REQ-030 DONE: cnt SHALL be cleared to 0.
REQ-031 DONE exit: go to IDLE and clear rel_pend if rel_pend is set, else go to HOLD.
REQ-032 key_release in COMPUTE, LOAD or DONE SHALL set rel_pend.
REQ-033 frame_done in COMPUTE, LOAD or DONE SHALL be dropped; exactly one load occurs per frame.
REQ-034 key_valid in COMPUTE, LOAD or DONE SHALL be ignored.
REQ-035 key SHALL change only in IDLE per REQ-017.

Reset
REQ-036 While rst=1, and after its release, state SHALL be IDLE with v0=1, v1=0, v2=0, ld_curr_camera=0, key=000, cnt=0, render_start=0, busy=0, rel_pend=0.
REQ-037 rst asserted in any state, including mid-LOAD, SHALL immediately force all values in REQ-036 with no further ld_curr_camera or render_start.

Verification
REQ-038 Press, frame, release: key_valid with code 010, 100 cycles, then frame_done -> cnt=100 frozen; busy for 24 cycles plus alignment; ld_curr_camera high for 3 cycles starting on a v0 cycle; then render_start pulse, cnt=0, state HOLD.
REQ-039 Release during COMPUTE: key_release there -> one load completes with its cnt value, then DONE returns to IDLE, and cnt does not count afterwards.
REQ-040 Edge cases: frame_done in IDLE -> render_start the next cycle and ld_curr_camera stays 0; key_code 111 -> state stays IDLE; a second key_valid (code 101) in HOLD -> key stays 010.
REQ-041 Saturation: with CNT_MAX=50, hold 200 cycles then frame_done -> cnt=50.
REQ-042 Reset mid-LOAD: rst pulse during the second LOAD cycle -> ld_curr_camera=0 immediately; outputs match REQ-036; v0=1 on the first cycle after release.
REQ-043 Dropped frames: a second frame_done during COMPUTE -> exactly one load and one render_start.

Source files
------------

// File: rtl/camera_ctrl.sv
// camera_ctrl: key-driven camera move sequencer.
// A held key accumulates a move magnitude (cnt); on frame_done the FSM freezes
// cnt and key, waits for the FP datapath to settle, issues a 3-cycle camera load
// aligned to the v0/v1/v2 phase rotation, and then releases the renderer.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   key_valid/key_code press pulse and 3-bit code (110/111 invalid)
//   key_release        release pulse for the held key
//   frame_done         renderer finished a frame
//   v0, v1, v2         free-running one-hot phase rotation
//   ld_curr_camera     camera register load request (LOAD state only)
//   key, cnt           latched key code and held-cycle count
//   render_start       one-cycle pulse: renderer may start next frame
//   busy               high in COMPUTE, LOAD, DONE
module camera_ctrl #(
    parameter int unsigned PIPE_LAT = 24,
    parameter logic [31:0] CNT_MAX  = 32'h00FF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [2:0]  key_code,
    input  logic        key_release,
    input  logic        frame_done,
    output logic        v0,
    output logic        v1,
    output logic        v2,
    output logic        ld_curr_camera,
    output logic [2:0]  key,
    output logic [31:0] cnt,
    output logic        render_start,
    output logic        busy
);

    // A zero latency still needs one COMPUTE cycle for the exit test.
    localparam int unsigned LAT    = (PIPE_LAT == 0) ? 1 : PIPE_LAT;
    localparam int unsigned WAIT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_COMPUTE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_phase;       // {v2, v1, v0}
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_rel_pend;
    logic                w_rel_pend_nxt;
    logic [2:0]          r_key;
    logic [2:0]          w_key_nxt;
    logic [31:0]         r_cnt;
    logic [31:0]         w_cnt_nxt;
    logic                r_ld;
    logic                w_ld_nxt;
    logic                r_rs;
    logic                w_rs_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                w_key_ok;
    logic                w_rel_any;

    assign w_key_ok  = (key_code <= 3'b101);
    assign w_rel_any = r_rel_pend | key_release;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_next_state   = r_state;
        w_wait_nxt     = r_wait;
        w_rel_pend_nxt = r_rel_pend;
        w_key_nxt      = r_key;
        w_cnt_nxt      = r_cnt;
        w_rs_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_rel_pend_nxt = 1'b0;
                if (frame_done) begin
                    w_rs_nxt = 1'b1;
                end
                if (key_valid && w_key_ok && !key_release) begin
                    w_next_state = S_HOLD;
                    w_key_nxt    = key_code;
                    w_cnt_nxt    = 32'd0;
                end
            end
            S_HOLD: begin
                if (r_rel_pend && (r_cnt == 32'd0)) begin
                    // Released before any movement: nothing to load.
                    w_next_state   = S_IDLE;
                    w_rel_pend_nxt = 1'b0;
                    w_rs_nxt       = frame_done;
                end else begin
                    if (key_release) begin
                        w_rel_pend_nxt = 1'b1;
                    end
                    if (!w_rel_any && (r_cnt != CNT_MAX)) begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                    if (frame_done) begin
                        w_next_state = S_COMPUTE;
                        w_wait_nxt   = '0;
                    end
                end
            end
            S_COMPUTE: begin
                w_rel_pend_nxt = w_rel_any;
                if (r_wait != WAIT_W'(LAT)) begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
                // Leave on v2 so the first LOAD cycle lands on v0.
                if ((r_wait >= WAIT_W'(LAT - 1)) && r_phase[2]) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rel_pend_nxt = w_rel_any;
                if (r_phase[2]) begin
                    w_next_state = S_DONE;
                    w_cnt_nxt    = 32'd0;
                end
            end
            S_DONE: begin
                if (w_rel_any) begin
                    w_next_state   = S_IDLE;
                    w_rel_pend_nxt = 1'b0;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            default: begin
                w_next_state   = S_IDLE;
                w_rel_pend_nxt = 1'b0;
            end
        endcase

        w_ld_nxt   = (w_next_state == S_LOAD);
        w_busy_nxt = (w_next_state == S_COMPUTE) || (w_next_state == S_LOAD) ||
                     (w_next_state == S_DONE);
        if (w_next_state == S_DONE) begin
            w_rs_nxt = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= 3'b001;
            r_wait     <= '0;
            r_rel_pend <= 1'b0;
            r_key      <= 3'b000;
            r_cnt      <= 32'd0;
            r_ld       <= 1'b0;
            r_rs       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_phase    <= {r_phase[1:0], r_phase[2]};
            r_wait     <= w_wait_nxt;
            r_rel_pend <= w_rel_pend_nxt;
            r_key      <= w_key_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ld       <= w_ld_nxt;
            r_rs       <= w_rs_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign v0             = r_phase[0];
    assign v1             = r_phase[1];
    assign v2             = r_phase[2];
    assign ld_curr_camera = r_ld;
    assign key            = r_key;
    assign cnt            = r_cnt;
    assign render_start   = r_rs;
    assign busy           = r_busy;

endmodule

// File: tb/tb_camera_ctrl.sv
// Bench for camera_ctrl: directed key/frame sequences with a load scoreboard.
module tb_camera_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [2:0]  key_code;
    logic        key_release;
    logic        frame_done;

    logic        v0, v1, v2, ld, rs, busy;
    logic [2:0]  key;
    logic [31:0] cnt;

    logic        s_v0, s_v1, s_v2, s_ld, s_rs, s_busy;
    logic [2:0]  s_key;
    logic [31:0] s_cnt;

    always #5 clk = ~clk;

    camera_ctrl u_dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_release(key_release), .frame_done(frame_done),
        .v0(v0), .v1(v1), .v2(v2), .ld_curr_camera(ld), .key(key), .cnt(cnt),
        .render_start(rs), .busy(busy)
    );

    camera_ctrl #(.CNT_MAX(32'd50)) u_sat (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_release(key_release), .frame_done(frame_done),
        .v0(s_v0), .v1(s_v1), .v2(s_v2), .ld_curr_camera(s_ld), .key(s_key),
        .cnt(s_cnt), .render_start(s_rs), .busy(s_busy)
    );

    typedef struct {
        logic [31:0] cnt;
        logic [2:0]  key;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ph_err   = 0;
    int ld_err   = 0;
    int n_ld     = 0;
    int n_rs     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic pulse_release();
        key_release = 1'b1;
        step();
        key_release = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] c, input logic [2:0] k);
        exp_t e;
        e.cnt = c;
        e.key = k;
        sb_q.push_back(e);
    endtask

    // Run until render_start, counting busy cycles and cnt deviations.
    task automatic run_to_done(input int max_cyc, input logic [31:0] frz,
                               output int busy_cyc, output int frz_err, output bit seen);
        busy_cyc = 0;
        frz_err  = 0;
        seen     = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (busy) busy_cyc++;
            if (rs) begin
                seen = 1'b1;
                break;
            end
            if (busy && (cnt != frz)) frz_err++;
        end
    endtask

    // Phase rotation, load framing and scoreboard monitor.
    initial begin
        logic [2:0] prev_ph;
        logic [2:0] cur;
        bit         prev_ok;
        int         ld_len;
        exp_t       e;
        prev_ok = 1'b0;
        ld_len  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ok = 1'b0;
                ld_len  = 0;
            end else begin
                cur = {v2, v1, v0};
                if (!$onehot(cur)) ph_err++;
                if (prev_ok && (cur != {prev_ph[1:0], prev_ph[2]})) ph_err++;
                prev_ph = cur;
                prev_ok = 1'b1;
                if (ld) begin
                    if (!busy) ld_err++;
                    if (ld_len == 0) begin
                        n_ld++;
                        if (!v0) ld_err++;
                        chk("sb_load_expected", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            chk("load_cnt", cnt, e.cnt);
                            chk("load_key", 32'(key), 32'(e.key));
                        end
                    end
                    if ((ld_len == 1) && !v1) ld_err++;
                    if ((ld_len == 2) && !v2) ld_err++;
                    ld_len++;
                end else begin
                    if ((ld_len != 0) && (ld_len != 3)) ld_err++;
                    ld_len = 0;
                end
                if (rs) n_rs++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  bc;
        int  fe;
        bit  seen;
        int  ld0;
        int  rs0;

        rst         = 1'b1;
        key_valid   = 1'b0;
        key_code    = 3'b000;
        key_release = 1'b0;
        frame_done  = 1'b0;

        // Reset values while held.
        repeat (3) step();
        chk("rst_phase", 32'({v2, v1, v0}), 32'b001);
        chk("rst_ld", 32'(ld), 0);
        chk("rst_key", 32'(key), 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_rs", 32'(rs), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        chk("rel_phase", 32'({v2, v1, v0}), 32'b001);
        step();

        // frame_done in IDLE.
        pulse_frame();
        chk("idle_frame_rs", 32'(rs), 1);
        chk("idle_frame_ld", 32'(ld), 0);
        chk("idle_frame_busy", 32'(busy), 0);
        step();
        chk("idle_frame_rs_end", 32'(rs), 0);

        // Invalid code 111 stays in IDLE.
        press(3'b111);
        chk("inv_key", 32'(key), 0);
        pulse_frame();
        chk("inv_idle_rs", 32'(rs), 1);
        chk("inv_idle_busy", 32'(busy), 0);
        step();

        // Press and release in the same cycle stays in IDLE.
        key_release = 1'b1;
        press(3'b011);
        key_release = 1'b0;
        chk("same_cyc_key", 32'(key), 0);
        pulse_frame();
        chk("same_cyc_rs", 32'(rs), 1);
        chk("same_cyc_busy", 32'(busy), 0);
        step();

        // Release before any count returns to IDLE.
        press(3'b011);
        chk("rel0_key", 32'(key), 32'b011);
        pulse_release();
        step();
        pulse_frame();
        chk("rel0_rs", 32'(rs), 1);
        chk("rel0_busy", 32'(busy), 0);
        step();

        // Press 010, second press ignored, 100 held cycles, frame.
        press(3'b010);
        chk("press_key", 32'(key), 32'b010);
        chk("press_cnt", cnt, 0);
        repeat (4) step();
        press(3'b101);
        chk("second_press_key", 32'(key), 32'b010);
        repeat (94) step();
        push_exp(32'd100, 3'b010);
        pulse_frame();
        chk("frame_cnt", cnt, 32'd100);
        chk("frame_busy", 32'(busy), 1);
        run_to_done(60, 32'd100, bc, fe, seen);
        chk("done_seen", 32'(seen), 1);
        chk("busy_len_ok", 32'((bc + 1 >= 28) && (bc + 1 <= 30)), 1);
        chk("cnt_frozen", 32'(fe), 0);
        chk("done_cnt", cnt, 0);
        step();
        chk("hold_after_done_busy", 32'(busy), 0);
        chk("hold_after_done_cnt", cnt, 0);
        step();
        chk("hold_counts", cnt, 32'd1);

        // Release and dropped frame during COMPUTE.
        repeat (9) step();
        push_exp(32'd11, 3'b010);
        pulse_frame();
        chk("rel_frame_cnt", cnt, 32'd11);
        ld0 = n_ld;
        rs0 = n_rs;
        repeat (4) step();
        pulse_frame();
        repeat (2) step();
        pulse_release();
        run_to_done(60, 32'd11, bc, fe, seen);
        chk("rel_done_seen", 32'(seen), 1);
        chk("rel_cnt_frozen", 32'(fe), 0);
        step();
        chk("rel_one_load", 32'(n_ld - ld0), 1);
        chk("rel_one_rs", 32'(n_rs - rs0), 1);
        chk("rel_idle_busy", 32'(busy), 0);
        repeat (10) step();
        chk("rel_no_count", cnt, 0);
        pulse_frame();
        chk("rel_idle_rs", 32'(rs), 1);
        chk("rel_idle_busy2", 32'(busy), 0);
        step();

        // Saturation: 200 held cycles, CNT_MAX=50 instance saturates.
        press(3'b100);
        repeat (199) step();
        push_exp(32'd200, 3'b100);
        pulse_frame();
        chk("sat_cnt", s_cnt, 32'd50);
        chk("nosat_cnt", cnt, 32'd200);
        repeat (3) step();
        pulse_release();
        run_to_done(60, 32'd200, bc, fe, seen);
        chk("sat_done_seen", 32'(seen), 1);
        step();
        chk("sat_idle_busy", 32'(busy), 0);
        repeat (3) step();

        // Reset during the second LOAD cycle.
        press(3'b001);
        repeat (19) step();
        push_exp(32'd20, 3'b001);
        pulse_frame();
        for (int i = 0; i < 40; i++) begin
            step();
            if (ld) break;
        end
        chk("rl_ld_first", 32'(ld), 1);
        step();
        chk("rl_ld_second", 32'(ld), 1);
        rst = 1'b1;
        #1;
        ld0 = n_ld;
        rs0 = n_rs;
        chk("rl_ld", 32'(ld), 0);
        chk("rl_rs", 32'(rs), 0);
        chk("rl_busy", 32'(busy), 0);
        chk("rl_key", 32'(key), 0);
        chk("rl_cnt", cnt, 0);
        chk("rl_phase", 32'({v2, v1, v0}), 32'b001);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rl_rel_phase", 32'({v2, v1, v0}), 32'b001);
        repeat (40) step();
        chk("rl_no_load", 32'(n_ld - ld0), 0);
        chk("rl_no_rs", 32'(n_rs - rs0), 0);
        chk("rl_idle_busy", 32'(busy), 0);

        chk("phase_rotation", 32'(ph_err), 0);
        chk("load_framing", 32'(ld_err), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
